// File: rtl/memarb_pkg.sv
// Purpose: shared types and constants for the two-requester data-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package memarb_pkg;

  // Arbiter ownership state: free for arbitration, or held by a locked burst.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  // Requester indices: CPU load/store port and loader/DMA port.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  // Default widths and burst limit.
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_BURST_MAX = 4;

  // Ownership state held by requester idx.
  function automatic state_e own_state(input logic idx);
    return (idx == REQ_DMA) ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Purpose: combinational 2-way round-robin selector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the loser simply sees no grant and keeps requesting.
// Ports: req0_i/req1_i requests, last_i most recently granted index,
//        winner_o selected index, valid_o any request present.
module rr_pick2
  import memarb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic winner_o,
  output logic valid_o
);

  always_comb begin
    valid_o  = req0_i | req1_i;
    winner_o = REQ_CPU;
    if (req0_i && req1_i) begin
      // Tie: the requester that was not served last wins.
      winner_o = ~last_i;
    end else if (req1_i) begin
      winner_o = REQ_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter with locked bursts sharing one single-port data memory.
// Latency: grant same cycle as request; write commits at the closing edge; read data +1 cycle.
// Backpressure: a requester without gnt must hold req/we/addr/wdata; bursts cap the wait at BURST_MAX.
// Ports: req*/lock*/we*/addr*/wdata* requester side, gnt* combinational grants,
//        rvalid*/rdata registered read return, mem_* memory side.
// Optional: define MEMARB_PERF_CNT_EN to add the 16-bit saturating conflict_cnt output.
module mem_arbiter
  import memarb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEMARB_PERF_CNT_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BMAX = CNT_W'(BURST_MAX);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata_q;

  logic pick_win, pick_vld;
  logic keep0, keep1;
  logic grant_any, grant_idx;
  logic win_lock;
  logic rd0, rd1;

  rr_pick2 u_pick (
    .req0_i   (req0),
    .req1_i   (req1),
    .last_i   (last_q),
    .winner_o (pick_win),
    .valid_o  (pick_vld)
  );

  assign win_lock = (pick_win == REQ_DMA) ? lock1 : lock0;

  // The owner keeps the memory while it still asks with lock, unless it has
  // used up its burst allowance and the other side is waiting.
  assign keep0 = (state_q == ST_OWN0) && req0 && lock0 && ((burst_q < BMAX) || !req1);
  assign keep1 = (state_q == ST_OWN1) && req1 && lock1 && ((burst_q < BMAX) || !req0);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    burst_d   = burst_q;
    grant_any = 1'b0;
    grant_idx = REQ_CPU;

    if (keep0 || keep1) begin
      grant_any = 1'b1;
      grant_idx = keep1 ? REQ_DMA : REQ_CPU;
      burst_d   = (burst_q == BMAX) ? burst_q : burst_q + 1'b1;
    end else if (pick_vld) begin
      // Released or idle: arbitrate in the same cycle so there is no bubble.
      grant_any = 1'b1;
      grant_idx = pick_win;
      if (win_lock) begin
        state_d = own_state(pick_win);
        burst_d = CNT_W'(1);
      end else begin
        state_d = ST_IDLE;
        burst_d = '0;
      end
    end else begin
      state_d = ST_IDLE;
      burst_d = '0;
    end

    if (grant_any) begin
      last_d = grant_idx;
    end
  end

  // Grants are gated by reset so nothing reaches memory while rst_n is low.
  assign gnt0 = rst_n & grant_any & (grant_idx == REQ_CPU);
  assign gnt1 = rst_n & grant_any & (grant_idx == REQ_DMA);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  assign rd0 = gnt0 & ~we0;
  assign rd1 = gnt1 & ~we1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= REQ_DMA;
      burst_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      rvalid0_q <= rd0;
      rvalid1_q <= rd1;
      if (rd0 || rd1) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = rdata_q;

`ifdef MEMARB_PERF_CNT_EN
  logic [15:0] conflict_q;
  logic        conflict;

  // One count per cycle in which at least one requester is kept waiting.
  assign conflict = (req0 & ~gnt0) | (req1 & ~gnt1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= '0;
    end else if (conflict && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the CPU's single-port 16-bit data memory. It shares the memory between the CPU load/store port (requester 0) and a loader/DMA port (requester 1) that fills or inspects memory while the program runs. Arbitration is round-robin with optional locked bursts. Memory writes commit on the grant cycle; read data returns registered one cycle later. It sits between the datapath's ALU-address/read2 outputs and the `mem` instance.

## Interface
- `DATA_W`, 16, data width
- `ADDR_W`, 16, address width
- `BURST_MAX`, 4, max consecutive locked grants while the other requester waits (≥1)

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req0`, `req1`  in  1  access request; held until granted
- `lock0`, `lock1`  in  1  request to keep ownership for following cycles
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  ADDR_W  access address
- `wdata0`, `wdata1`  in  DATA_W  write data
- `gnt0`, `gnt1`  out  1  combinational grant; access performed this cycle
- `rvalid0`, `rvalid1`  out  1  registered; read data valid
- `rdata`  out  DATA_W  registered read data (shared; qualified by `rvalid*`)
- `mem_we`  out  1  to memory write enable
- `mem_addr`  out  ADDR_W  to memory address
- `mem_wdata`  out  DATA_W  to memory write data
- `mem_rdata`  in  DATA_W  combinational read data from memory

## Operation
- States: IDLE, OWN0, OWN1. The `last` pointer records the most recently granted requester.
- IDLE:
  - Exactly one request: grant it.
  - Both request: grant the requester ≠ `last`.
  - Winner has lock=1: go to OWNwinner with `burst_cnt`=1.
  - Otherwise stay in IDLE.
- OWNi:
  - `reqi && locki` and (`burst_cnt` < BURST_MAX or other requester idle): grant i again and increment `burst_cnt`, saturating at BURST_MAX.
  - Otherwise ownership is released. The same cycle arbitrates exactly as IDLE, so there is no bubble, and the next state follows the IDLE rules.
- A lock without a request is ignored.
- Muxing:
  - Granted requester's we/addr/wdata drive `mem_*`.
  - No grant: `mem_we`=0, `mem_addr`/`mem_wdata`=0.
  - At most one `gnt` is ever high.
- Reads: on the grant cycle with we=0, `mem_rdata` is captured into `rdata` and the `rvalid` of the granted requester is set for one cycle. Writes never raise `rvalid`.
- `last` updates on every grant.

## Timing
- Reset values (`rst_n`=0, asynchronous): state=IDLE, `last`=1 (requester 0 wins the first tie), `burst_cnt`=0, `rvalid0/1`=0, `rdata`=0.
- While `rst_n`=0, `gnt0/1` and `mem_we` are forced to 0.
- Reset asserted mid-burst: the burst is abandoned and no write commits in the reset cycle.
- Grant latency from a request in IDLE with no contention: 0 cycles (same cycle).
- The write commits at the rising edge ending the grant cycle.
- Read latency: `rvalid`/`rdata` at grant cycle +1.
- Worst-case wait for a requester while the other bursts: BURST_MAX cycles.
- Back-to-back unlocked contention alternates grants every cycle.
- Requesters must hold req/we/addr/wdata stable until they see `gnt`.

## Configuration
- `MEMARB_PERF_CNT_EN` defined:
  - Adds output `conflict_cnt` (16 bits): counts cycles where a requester has req=1 and gnt=0.
  - Saturates at 0xFFFF; reset to 0.
- Undefined: the port and the counter are absent. Arbitration behaviour is identical.

## Structure
- Shared package `memarb_pkg`:
  - state enum (IDLE/OWN0/OWN1)
  - requester index constants (REQ_CPU=0, REQ_DMA=1)
  - default widths
- One sub-module: `rr_pick2`, a combinational 2-way round-robin selector (req0, req1, last → winner, valid).
- The FSM, muxing and read register live in `mem_arbiter`.

## Test plan
- Reset release, `req0`=1, `we0`=1, `addr0`=0x0010, `wdata0`=0xBEEF → `gnt0`=1 same cycle; memory[0x10]=0xBEEF after the edge; `rvalid0`=0.
- Read back, `req1`=1, `we1`=0, `addr1`=0x0010 → `gnt1`=1; next cycle `rvalid1`=1, `rdata`=0xBEEF; `rvalid1`=0 the cycle after.
- Both request constantly, no lock, starting from reset → grants alternate 0,1,0,1; at most one `gnt` high.
- `req0`+`lock0` held, `req1` held, BURST_MAX=4 → `gnt0` for 4 cycles, then `gnt1` on cycle 5 with no idle cycle; with `req1`=0 the burst continues beyond 4.
- `rst_n` pulsed low for half a cycle during an OWN0 write burst → `gnt0`=0 and `mem_we`=0 immediately; state IDLE; `rvalid`=0; next tie is won by requester 0.
- With `MEMARB_PERF_CNT_EN`: 3 cycles of contention → `conflict_cnt`=3. Without the macro the design compiles and has no `conflict_cnt` port.
